ctrl_vector_driver: RTL and testbench
=====================================

Name: ctrl_vector_driver

Overview:
- Synthesizable vector player and checker that sits on the opposite side of the controller interface from the controller.
- It drives `op` and `zero` into the controller and samples the returned 14-bit control word.
- It compares each sample against a stored expected word and reports pass/fail, error count and first-failure details.
- It is the on-chip, self-checking counterpart of the controller decoder and is used for board-level bring-up of the control path.

Parameters:
- DEPTH, 16: number of vector slots. Must be a power of two, ≥ 2.
- SETTLE, 1: wait cycles between driving `op`/`zero` and sampling `control`. Range 0–7.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- load_we  input  1  write strobe for the vector memory.
- load_addr  input  $clog2(DEPTH)  vector slot address.
- load_data  input  19  vector word {op[3:0], zero, expected[13:0]}; bit 18 is op MSB.
- num_vec  input  $clog2(DEPTH)+1  number of vectors to run; latched on start.
- start  input  1  single-cycle run request.
- op  output  4  opcode driven to the controller.
- zero  output  1  ALU zero flag driven to the controller.
- control  input  14  {regWrite, regDst[1:0], memWrite, memToReg[1:0], jump[1:0], aluSrc[1:0], pcSrc, aluCtrl[2:0]} from the controller.
- busy  output  1  high while a run is in progress.
- done  output  1  high after a run completes; held until the next start.
- pass  output  1  valid while done; high when err_count == 0.
- err_count  output  8  mismatch count, saturates at 255.
- first_err_idx  output  $clog2(DEPTH)  index of the first mismatching vector.
- first_err_ctrl  output  14  control word actually sampled at the first mismatch.
- first_err_vld  output  1  set when a first mismatch has been captured.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0: op, zero, busy, done, pass, err_count, first_err_*.
  - Vector memory is not cleared.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE. busy = (state ∈ {DRIVE, SETTLE, CHECK}).
- Memory writes:
  - Accepted on a rising edge with load_we=1 while in IDLE or DONE.
  - Ignored while busy.
  - Reads are registered from the current index.
- start in IDLE or DONE:
  - Latch num_vec.
  - Clear err_count, first_err_*, done and pass; set idx=0.
  - If the latched num_vec == 0, go to DONE on the next edge with pass=1.
  - Otherwise go to DRIVE.
  - start while busy is ignored.
- DRIVE (one cycle): register op and zero from mem[idx], and expected from mem[idx][13:0]. Next state is SETTLE if SETTLE > 0, else CHECK.
- SETTLE: count SETTLE cycles with op and zero held stable, then go to CHECK.
- CHECK (one cycle): sample `control` at the rising edge.
  - Mismatch = (control != expected), compared bitwise on all 14 bits.
  - On mismatch: err_count += 1, saturating at 255.
  - On the first mismatch of the run: capture idx into first_err_idx and control into first_err_ctrl, and set first_err_vld=1.
  - Then: if idx == num_vec-1, go to DONE; else idx += 1 and go to DRIVE.
- Per-vector latency is 2+SETTLE cycles. A full run takes num_vec*(2+SETTLE) cycles from the start edge until done rises.
- DONE:
  - done=1 and pass = (err_count == 0); both are registered on DONE entry.
  - op and zero hold the last vector.
  - Status stays stable until the next start.
- num_vec > DEPTH: clamp to DEPTH when latched. Index never wraps past DEPTH-1.
- start and load_we in the same cycle while in IDLE/DONE: the write happens and the run starts. The write lands before the first DRIVE read, so a write to slot 0 is used.
- Reset mid-run: immediate abort to IDLE with outputs cleared. The partial count is lost.

Test Plan:
1. Load slot 0 = {4'b0000, 1'b0, 14'b10100000000010} with an R-type-correct controller attached; num_vec=1, start → done rises 3 cycles after start (SETTLE=1), pass=1, err_count=0, first_err_vld=0.
2. Load 4 vectors with slot 2's expected aluCtrl flipped (…010 → …011), num_vec=4 → done after 12 cycles, pass=0, err_count=1, first_err_idx=2, first_err_ctrl = true controller output for slot 2.
3. num_vec=0, start → done=1 and pass=1 on the following edge; op and zero stay 0; busy never rises.
4. Stub `control` to a constant that mismatches every vector; run DEPTH=16 vectors three times without restart, and separately force 300 mismatches by repeated runs with a modified counter bench → err_count clears per run, stays ≤ 255, and saturates at 255 (no wrap to 44).
5. Assert reset for 3 ns mid-SETTLE of vector 1 → op, zero, busy and err_count are 0 asynchronously before the next edge; a subsequent start reruns from idx 0 with correct results.
6. Pulse start and load_we while busy → no restart, memory unchanged (verify by re-running and checking the original results), run completes normally.

Source files
------------

// File: rtl/ctrl_vector_driver_if.sv
// Bus between the vector driver and its host/controller side: vector loading,
// run control, the op/zero/control path and the run status.
interface ctrl_vector_driver_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [18:0]   load_data;
  logic [AW:0]   num_vec;
  logic          start;
  logic [3:0]    op;
  logic          zero;
  logic [13:0]   control;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    err_count;
  logic [AW-1:0] first_err_idx;
  logic [13:0]   first_err_ctrl;
  logic          first_err_vld;

  // Driver side: plays vectors and reports status.
  modport slave (
    input  load_we, load_addr, load_data, num_vec, start, control,
    output op, zero, busy, done, pass, err_count,
           first_err_idx, first_err_ctrl, first_err_vld
  );

  // Host/controller side.
  modport master (
    output load_we, load_addr, load_data, num_vec, start, control,
    input  op, zero, busy, done, pass, err_count,
           first_err_idx, first_err_ctrl, first_err_vld
  );
endinterface

// File: rtl/ctrl_vector_driver.sv
// Vector player/checker: drives op/zero into the controller, samples the
// returned control word after SETTLE cycles and accumulates mismatch status.
module ctrl_vector_driver #(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  ctrl_vector_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW:0] DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   num_q, num_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          zero_q, zero_d;
  logic [13:0]   exp_q, exp_d;
  logic [7:0]    err_q, err_d;
  logic [AW-1:0] fidx_q, fidx_d;
  logic [13:0]   fctrl_q, fctrl_d;
  logic          fvld_q, fvld_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [18:0]   mem_q [DEPTH];
  logic [18:0]   rd_word;
  logic [AW:0]   num_clamp;
  logic [7:0]    err_next;
  logic          mismatch;
  logic          busy;

  assign busy = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);

  // NOTE: the vector store has no reset so it survives a mid-run abort and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (bus.load_we && !busy) mem_q[bus.load_addr] <= bus.load_data;
  end

  assign rd_word   = mem_q[idx_q];
  assign num_clamp = (bus.num_vec > DEPTH_W) ? DEPTH_W : bus.num_vec;
  assign mismatch  = (bus.control != exp_q);
  assign err_next  = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    zero_d  = zero_q;
    exp_d   = exp_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fctrl_d = fctrl_q;
    fvld_d  = fvld_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          num_d   = num_clamp;
          idx_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fctrl_d = '0;
          fvld_d  = 1'b0;
          if (num_clamp == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_DRIVE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      S_DRIVE: begin
        op_d    = rd_word[18:15];
        zero_d  = rd_word[14];
        exp_d   = rd_word[13:0];
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
        else                      cnt_d   = cnt_q + 3'd1;
      end
      S_CHECK: begin
        err_d = err_next;
        if (mismatch && !fvld_q) begin
          fidx_d  = idx_q;
          fctrl_d = bus.control;
          fvld_d  = 1'b1;
        end
        if ({1'b0, idx_q} == num_q - 1'b1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_next == 8'd0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
      exp_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fctrl_q <= '0;
      fvld_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fctrl_q <= fctrl_d;
      fvld_q  <= fvld_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.op             = op_q;
  assign bus.zero           = zero_q;
  assign bus.busy           = busy;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_idx  = fidx_q;
  assign bus.first_err_ctrl = fctrl_q;
  assign bus.first_err_vld  = fvld_q;
endmodule

// File: tb/tb_ctrl_vector_driver.sv
// Bench for ctrl_vector_driver: table of runs against a modelled controller,
// plus hand sequences for reset abort, busy-time pulses and error saturation.
module tb_ctrl_vector_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ctrl_vector_driver_if #(.DEPTH(16))  b1 ();
  ctrl_vector_driver_if #(.DEPTH(256)) b2 ();

  ctrl_vector_driver #(.DEPTH(16), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );
  ctrl_vector_driver #(.DEPTH(256), .SETTLE(1)) dut_sat (
    .clk(clk), .reset(reset), .bus(b2.slave)
  );

  int tests = 0;
  int fails = 0;

  // Hand-written control words of a small single-cycle controller.
  localparam logic [13:0] W_R   = 14'b1_01_0_00_00_00_0_010;
  localparam logic [13:0] W_LW  = 14'b1_00_0_01_00_01_0_010;
  localparam logic [13:0] W_SW  = 14'b0_00_1_00_00_01_0_010;
  localparam logic [13:0] W_BQ0 = 14'b0_00_0_00_00_00_0_110;
  localparam logic [13:0] W_BQ1 = 14'b0_00_0_00_00_00_1_110;
  localparam logic [13:0] W_SWX = 14'b0_00_1_00_00_01_0_011;

  function automatic logic [13:0] ctrl_model(input logic [3:0] op, input logic zero);
    case (op)
      4'd0:    return W_R;
      4'd1:    return W_LW;
      4'd2:    return W_SW;
      4'd3:    return zero ? W_BQ1 : W_BQ0;
      default: return 14'h0;
    endcase
  endfunction

  logic        stub_en = 1'b0;
  logic [13:0] stub_val = 14'h0;
  assign b1.control = stub_en ? stub_val : ctrl_model(b1.op, b1.zero);
  assign b2.control = 14'h3FFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load1(input logic [3:0] addr, input logic [18:0] data);
    b1.load_we = 1'b1; b1.load_addr = addr; b1.load_data = data;
    @(posedge clk); #1;
    b1.load_we = 1'b0;
  endtask

  // Start a run and count cycles from the start edge until done rises.
  task automatic run1(input logic [4:0] n, output int cyc);
    b1.num_vec = n; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    cyc = 0;
    while (!b1.done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!b1.done) check("run_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  num;
    logic        stub;
    logic [13:0] sval;
    int          cycles;
    logic        pass;
    logic [7:0]  err;
    logic        fvld;
    logic [3:0]  fidx;
    logic [13:0] fctrl;
    logic [3:0]  op;
    logic        zero;
  } run_t;

  run_t runs [7];

  initial begin
    int cyc;
    runs[0] = '{"empty",  5'd0,  1'b0, 14'h0,    0, 1'b1, 8'd0,  1'b0, 4'd0, 14'h0,  4'd0, 1'b0};
    runs[1] = '{"single", 5'd1,  1'b0, 14'h0,    3, 1'b1, 8'd0,  1'b0, 4'd0, 14'h0,  4'd0, 1'b0};
    runs[2] = '{"four",   5'd4,  1'b0, 14'h0,   12, 1'b0, 8'd1,  1'b1, 4'd2, W_SW,   4'd3, 1'b1};
    runs[3] = '{"stub1",  5'd16, 1'b1, 14'h3FFF, 48, 1'b0, 8'd16, 1'b1, 4'd0, 14'h3FFF, 4'd0, 1'b0};
    runs[4] = '{"stub2",  5'd16, 1'b1, 14'h3FFF, 48, 1'b0, 8'd16, 1'b1, 4'd0, 14'h3FFF, 4'd0, 1'b0};
    runs[5] = '{"clamp",  5'd20, 1'b0, 14'h0,   48, 1'b0, 8'd1,  1'b1, 4'd2, W_SW,   4'd0, 1'b0};
    runs[6] = '{"three",  5'd3,  1'b0, 14'h0,    9, 1'b0, 8'd1,  1'b1, 4'd2, W_SW,   4'd2, 1'b0};

    b1.load_we = 1'b0; b1.load_addr = '0; b1.load_data = '0; b1.num_vec = '0; b1.start = 1'b0;
    b2.load_we = 1'b0; b2.load_addr = '0; b2.load_data = '0; b2.num_vec = '0; b2.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", 32'(b1.busy), 32'd0);
    check("rst_done", 32'(b1.done), 32'd0);
    check("rst_pass", 32'(b1.pass), 32'd0);
    check("rst_op",   32'(b1.op), 32'd0);
    check("rst_err",  32'(b1.err_count), 32'd0);
    check("rst_fvld", 32'(b1.first_err_vld), 32'd0);

    load1(4'd0, {4'd0, 1'b0, W_R});
    load1(4'd1, {4'd1, 1'b0, W_LW});
    load1(4'd2, {4'd2, 1'b0, W_SWX});
    load1(4'd3, {4'd3, 1'b1, W_BQ1});
    for (int i = 4; i < 16; i++) load1(4'(i), {4'd0, 1'b0, W_R});

    for (int i = 0; i < 7; i++) begin
      stub_en = runs[i].stub; stub_val = runs[i].sval;
      run1(runs[i].num, cyc);
      check({runs[i].name, "_cycles"}, 32'(cyc), 32'(runs[i].cycles));
      check({runs[i].name, "_busy"},   32'(b1.busy), 32'd0);
      check({runs[i].name, "_pass"},   32'(b1.pass), 32'(runs[i].pass));
      check({runs[i].name, "_err"},    32'(b1.err_count), 32'(runs[i].err));
      check({runs[i].name, "_fvld"},   32'(b1.first_err_vld), 32'(runs[i].fvld));
      check({runs[i].name, "_fidx"},   32'(b1.first_err_idx), 32'(runs[i].fidx));
      check({runs[i].name, "_fctrl"},  32'(b1.first_err_ctrl), 32'(runs[i].fctrl));
      check({runs[i].name, "_op"},     32'(b1.op), 32'(runs[i].op));
      check({runs[i].name, "_zero"},   32'(b1.zero), 32'(runs[i].zero));
      repeat (2) @(posedge clk);
      #1 check({runs[i].name, "_hold"}, 32'(b1.done), 32'd1);
    end
    stub_en = 1'b0;

    // Asynchronous reset in the SETTLE cycle of vector 1.
    b1.num_vec = 5'd4; b1.start = 1'b1;
    @(posedge clk); #1 b1.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("abort_pre_op",   32'(b1.op), 32'd1);
    check("abort_pre_busy", 32'(b1.busy), 32'd1);
    reset = 1'b1;
    #2;
    check("abort_op",   32'(b1.op), 32'd0);
    check("abort_zero", 32'(b1.zero), 32'd0);
    check("abort_busy", 32'(b1.busy), 32'd0);
    check("abort_err",  32'(b1.err_count), 32'd0);
    check("abort_done", 32'(b1.done), 32'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run1(5'd4, cyc);
    check("rerun_cycles", 32'(cyc), 32'd12);
    check("rerun_err",    32'(b1.err_count), 32'd1);
    check("rerun_fidx",   32'(b1.first_err_idx), 32'd2);

    // start/load_we pulsed mid-run: slot 2 would be repaired if the write landed.
    b1.num_vec = 5'd4; b1.start = 1'b1;
    @(posedge clk); #1 b1.start = 1'b0;
    cyc = 0;
    repeat (2) begin @(posedge clk); #1 cyc++; end
    b1.start = 1'b1; b1.num_vec = 5'd1;
    b1.load_we = 1'b1; b1.load_addr = 4'd2; b1.load_data = {4'd2, 1'b0, W_SW};
    @(posedge clk); #1 cyc++;
    b1.start = 1'b0; b1.load_we = 1'b0;
    while (!b1.done && cyc < 2000) begin @(posedge clk); #1 cyc++; end
    check("busy_cycles", 32'(cyc), 32'd12);
    check("busy_err",    32'(b1.err_count), 32'd1);
    check("busy_fidx",   32'(b1.first_err_idx), 32'd2);
    run1(5'd4, cyc);
    check("busy_mem_err",  32'(b1.err_count), 32'd1);
    check("busy_mem_fctl", 32'(b1.first_err_ctrl), 32'(W_SW));

    // Write to slot 0 in the same cycle as start: the new word is used.
    b1.load_we = 1'b1; b1.load_addr = 4'd0; b1.load_data = {4'd0, 1'b0, 14'h0};
    run1(5'd1, cyc);
    b1.load_we = 1'b0;
    check("same_err",   32'(b1.err_count), 32'd1);
    check("same_fidx",  32'(b1.first_err_idx), 32'd0);
    check("same_fctrl", 32'(b1.first_err_ctrl), 32'(W_R));
    check("same_pass",  32'(b1.pass), 32'd0);

    // 256 mismatches in one run saturate the counter; num_vec=300 clamps to 256.
    for (int i = 0; i < 256; i++) begin
      b2.load_we = 1'b1; b2.load_addr = 8'(i); b2.load_data = 19'h0;
      @(posedge clk); #1;
    end
    b2.load_we = 1'b0;
    b2.num_vec = 9'd300; b2.start = 1'b1;
    @(posedge clk); #1 b2.start = 1'b0;
    cyc = 0;
    while (!b2.done && cyc < 2000) begin @(posedge clk); #1 cyc++; end
    check("sat_cycles", 32'(cyc), 32'd768);
    check("sat_err",    32'(b2.err_count), 32'd255);
    check("sat_fidx",   32'(b2.first_err_idx), 32'd0);
    check("sat_pass",   32'(b2.pass), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
